// File: rtl/integral_image_gen.sv
// integral_image_gen
//
// Builds a summed-area table for one core tile. It takes raw grey pixels in
// raster order and returns, for every pixel, the sum of all pixels above and to
// the left of it, inclusive. Each result carries its linear address y*width + x.
// The face-detection filter loads this stream as its image memory.
//
// Optional feature: define INTEGRAL_SQ_EN to add sq_out. This is a second
// integral of pix_in*pix_in, used for variance normalisation. It has its own
// line buffer and shares the sum_out handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low; clears the block on the next clk edge
//   start      one-cycle tile request, sampled only in IDLE
//   width      tile width in pixels, latched on an accepted start
//   height     tile height in pixels, latched on an accepted start
//   pix_in     unsigned input pixel
//   pix_valid  pix_in is valid
//   pix_ready  block accepts pix_in this cycle
//   sum_out    integral value
//   sum_addr   linear address y*width + x of sum_out
//   sum_valid  sum_out / sum_addr are valid
//   sum_ready  downstream accepts the output
//   busy       high while a tile is running
//   done       one-cycle pulse when a tile completes or a start is rejected
//   cfg_err    sticky: last start was rejected; cleared by the next accepted start
//   sq_out     (INTEGRAL_SQ_EN only) squared-pixel integral, valid with sum_out

module integral_image_gen #(
   parameter int unsigned PIX_W     = 8,
   parameter int unsigned SUM_W     = 32,
   parameter int unsigned MAX_WIDTH = 1024,
   parameter int unsigned DIM_W     = 11,
   parameter int unsigned ADDR_W    = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic [SUM_W-1:0]  sum_out,
   output logic [ADDR_W-1:0] sum_addr,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
`ifdef INTEGRAL_SQ_EN
   ,
   output logic [2*SUM_W-1:0] sq_out
`endif
);

   localparam int unsigned XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int unsigned AW = 2 * DIM_W;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t             state_q;
   logic [DIM_W-1:0]   width_q;
   logic [DIM_W-1:0]   height_q;
   logic [DIM_W-1:0]   x_q;
   logic [DIM_W-1:0]   y_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [SUM_W-1:0]   rowacc_q;
   logic               last_taken_q;

   logic [SUM_W-1:0]   linebuf [MAX_WIDTH];

   logic [AW-1:0]      area;
   logic               cfg_ok;
   logic               xfer;
   logic               x_last;
   logic               y_last;
   logic [XW-1:0]      lb_idx;
   logic [SUM_W-1:0]   above;
   logic [SUM_W-1:0]   rowacc_d;
   logic [SUM_W-1:0]   ii;

   // ------------------------------------------------------------------------
   // Configuration check at start
   // ------------------------------------------------------------------------
   assign area   = AW'(width) * AW'(height);
   assign cfg_ok = (width != '0) && (32'(width) <= MAX_WIDTH) &&
                   (height != '0) && (64'(area) <= (64'd1 << ADDR_W));

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   // Once the final pixel is in, stop accepting input until the tile retires.
   assign pix_ready = (state_q == StRun) && (!sum_valid || sum_ready) && !last_taken_q;
   assign xfer      = pix_valid && pix_ready;

   assign x_last = (x_q == width_q - DIM_W'(1));
   assign y_last = (y_q == height_q - DIM_W'(1));
   assign lb_idx = x_q[XW-1:0];

   // ------------------------------------------------------------------------
   // Integral arithmetic
   // ------------------------------------------------------------------------
   // The line-buffer read is combinational and the write happens at the clock
   // edge. A read therefore returns the value from the previous row.
   always_comb begin
      above    = (y_q == '0) ? '0 : linebuf[lb_idx];
      rowacc_d = ((x_q == '0) ? '0 : rowacc_q) + SUM_W'(pix_in);
      ii       = rowacc_d + above;
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         linebuf[lb_idx] <= ii;
      end
   end

`ifdef INTEGRAL_SQ_EN
   logic [2*PIX_W-1:0]  sq_pix;
   logic [2*SUM_W-1:0]  sq_rowacc_q;
   logic [2*SUM_W-1:0]  sq_rowacc_d;
   logic [2*SUM_W-1:0]  sq_above;
   logic [2*SUM_W-1:0]  sq_ii;
   logic [2*SUM_W-1:0]  sq_linebuf [MAX_WIDTH];

   always_comb begin
      sq_pix      = (2*PIX_W)'(pix_in) * (2*PIX_W)'(pix_in);
      sq_above    = (y_q == '0) ? '0 : sq_linebuf[lb_idx];
      sq_rowacc_d = ((x_q == '0) ? '0 : sq_rowacc_q) + (2*SUM_W)'(sq_pix);
      sq_ii       = sq_rowacc_d + sq_above;
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         sq_linebuf[lb_idx] <= sq_ii;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sq_rowacc_q <= '0;
         sq_out      <= '0;
      end else if (xfer) begin
         sq_rowacc_q <= sq_rowacc_d;
         sq_out      <= sq_ii;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Control FSM with registered status outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         busy     <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
         width_q  <= '0;
         height_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (cfg_ok) begin
                     state_q  <= StRun;
                     busy     <= 1'b1;
                     cfg_err  <= 1'b0;
                     width_q  <= width;
                     height_q <= height;
                  end else begin
                     state_q <= StDone;
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                  end
               end
            end
            StRun: begin
               // When last_taken_q is set, the output register holds the final pixel.
               if (sum_valid && sum_ready && last_taken_q) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Position counters and the one-deep output stage
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         rowacc_q     <= '0;
         last_taken_q <= 1'b0;
         sum_out      <= '0;
         sum_addr     <= '0;
         sum_valid    <= 1'b0;
      end else begin
         if (state_q == StIdle && start && cfg_ok) begin
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            last_taken_q <= 1'b0;
         end

         if (xfer) begin
            rowacc_q  <= rowacc_d;
            sum_out   <= ii;
            sum_addr  <= addr_q;
            sum_valid <= 1'b1;
            // Raster order makes y*width + x equal to the transfer count.
            addr_q    <= addr_q + ADDR_W'(1);
            if (x_last) begin
               x_q <= '0;
               y_q <= y_q + DIM_W'(1);
               if (y_last) begin
                  last_taken_q <= 1'b1;
               end
            end else begin
               x_q <= x_q + DIM_W'(1);
            end
         end else if (sum_ready) begin
            sum_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed testbench for integral_image_gen. Expected integrals are computed by hand.
module tb_integral_image_gen;

   localparam int unsigned PIX_W     = 8;
   localparam int unsigned SUM_W     = 32;
   localparam int unsigned MAX_WIDTH = 1024;
   localparam int unsigned DIM_W     = 11;
   localparam int unsigned ADDR_W    = 17;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [DIM_W-1:0]  width;
   logic [DIM_W-1:0]  height;
   logic [PIX_W-1:0]  pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [SUM_W-1:0]  sum_out;
   logic [ADDR_W-1:0] sum_addr;
   logic              sum_valid;
   logic              sum_ready;
   logic              busy;
   logic              done;
   logic              cfg_err;
`ifdef INTEGRAL_SQ_EN
   logic [2*SUM_W-1:0] sq_out;
   longint unsigned    exp_sq[$];
`endif

   int                total = 0;
   int                bad   = 0;
   int                pix_q[$];
   longint unsigned   exp_sum[$];
   bit                rdy_pat[$];

   always #5 clk = ~clk;

   integral_image_gen #(
      .PIX_W     (PIX_W),
      .SUM_W     (SUM_W),
      .MAX_WIDTH (MAX_WIDTH),
      .DIM_W     (DIM_W),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .width     (width),
      .height    (height),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .sum_out   (sum_out),
      .sum_addr  (sum_addr),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
`ifdef INTEGRAL_SQ_EN
      ,
      .sq_out    (sq_out)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_start(input int w, input int h);
      @(negedge clk);
      start  = 1'b1;
      width  = DIM_W'(w);
      height = DIM_W'(h);
      @(negedge clk);
      start  = 1'b0;
      #1;
   endtask

   // Streams pix_q and checks each output against exp_sum. Output values are
   // also checked on every stalled cycle, which verifies they are held stable.
   task automatic run_tile(input bit chk_consec);
      int pi = 0;
      int oi = 0;
      int cyc = 0;
      int first = -1;
      int last = -1;
      int n = exp_sum.size();
      while (oi < n && cyc < 2000) begin
         @(negedge clk);
         sum_ready = rdy_pat[cyc % rdy_pat.size()];
         pix_valid = (pi < pix_q.size());
         pix_in    = pix_valid ? PIX_W'(pix_q[pi]) : '0;
         #1;
         if (sum_valid) begin
            check($sformatf("sum[%0d]", oi), 64'(sum_out), exp_sum[oi]);
            check($sformatf("addr[%0d]", oi), 64'(sum_addr), 64'(oi));
`ifdef INTEGRAL_SQ_EN
            if (oi < exp_sq.size()) check($sformatf("sq[%0d]", oi), sq_out, exp_sq[oi]);
`endif
            if (!sum_ready) begin
               check("stall_pix_ready", 64'(pix_ready), 64'd0);
            end else begin
               if (first < 0) first = cyc;
               last = cyc;
               oi++;
            end
         end
         if (pix_valid && pix_ready) pi++;
         cyc++;
      end
      pix_valid = 1'b0;
      sum_ready = 1'b1;
      check("out_count", 64'(oi), 64'(n));
      if (chk_consec) check("consecutive", 64'(last - first), 64'(n - 1));
   endtask

   task automatic finish_tile();
      int dn = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (done) dn++;
      end
      check("done_pulses", 64'(dn), 64'd1);
      check("busy_after", 64'(busy), 64'd0);
      check("valid_after", 64'(sum_valid), 64'd0);
   endtask

   task automatic reject(input int w, input int h, input string tag);
      do_start(w, h);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_cfg_err"}, 64'(cfg_err), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      @(negedge clk);
      #1;
      check({tag, "_done_low"}, 64'(done), 64'd0);
      check({tag, "_no_valid"}, 64'(sum_valid), 64'd0);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      width     = '0;
      height    = '0;
      pix_in    = '0;
      pix_valid = 1'b0;
      sum_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_pix_ready", 64'(pix_ready), 64'd0);
      check("rst_sum_valid", 64'(sum_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cfg_err", 64'(cfg_err), 64'd0);
      check("rst_sum_out", 64'(sum_out), 64'd0);
      check("rst_sum_addr", 64'(sum_addr), 64'd0);
      reset = 1'b1;

      // 3x3 of ones at full throughput
      rdy_pat = '{1'b1};
      pix_q   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      exp_sum = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
      do_start(3, 3);
      check("busy_run", 64'(busy), 64'd1);
      run_tile(1'b1);
      finish_tile();

      // 8x8 of 255: integral at (x,y) is 255*(x+1)*(y+1)
      pix_q.delete();
      exp_sum.delete();
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            pix_q.push_back(255);
            exp_sum.push_back(longint'(255 * (x + 1) * (y + 1)));
         end
      end
      do_start(8, 8);
      run_tile(1'b0);
      finish_tile();

      // 4x2 ramp with a stalling downstream
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      pix_q   = '{0, 1, 2, 3, 4, 5, 6, 7};
      exp_sum = '{0, 1, 3, 6, 4, 10, 18, 28};
      do_start(4, 2);
      run_tile(1'b0);
      finish_tile();
      rdy_pat = '{1'b1};

      // Rejected configurations
      reject(0, 3, "w0");
      reject(MAX_WIDTH + 1, 2, "wmax1");
      reject(3, 0, "h0");
      reject(MAX_WIDTH, 129, "area");

      // A valid start clears cfg_err
      pix_q   = '{5};
      exp_sum = '{5};
      do_start(1, 1);
      check("cfg_err_cleared", 64'(cfg_err), 64'd0);
      run_tile(1'b0);
      finish_tile();

      // Reset in the middle of a 4x4 tile
      pix_q   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      exp_sum = '{1, 2, 3, 4, 2};
      do_start(4, 4);
      run_tile(1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_valid", 64'(sum_valid), 64'd0);
      check("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
      check("mid_rst_sum_out", 64'(sum_out), 64'd0);
      begin
         int dn = 0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (done) dn++;
         end
         check("mid_rst_no_done", 64'(dn), 64'd0);
      end

      // New 2x2 tile of twos after the abandoned tile
      pix_q   = '{2, 2, 2, 2};
      exp_sum = '{2, 4, 4, 8};
      do_start(2, 2);
      run_tile(1'b1);
      finish_tile();

      // width==1 column: rowacc restarts on every pixel
      pix_q   = '{4, 5, 6};
      exp_sum = '{4, 9, 15};
      do_start(1, 3);
      run_tile(1'b0);
      finish_tile();

`ifdef INTEGRAL_SQ_EN
      pix_q   = '{3, 3, 3, 3};
      exp_sum = '{3, 6, 6, 12};
      exp_sq  = '{9, 18, 18, 36};
      do_start(2, 2);
      run_tile(1'b0);
      finish_tile();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
